// File: rtl/ebus_lane_arbiter_if.sv
// EBUS driver/merger bundle: driver claims and data in, merged bus and diagnostics out.
// master = the driver side, slave = the arbiter.
interface ebus_lane_arbiter_if #(
  parameter int NDRV  = 32,
  parameter int WIDTH = 36,
  parameter int LANEW = 6,
  parameter int CNTW  = 16
);
  localparam int NLANES = WIDTH / LANEW;
  localparam int OW     = (NDRV > 1) ? $clog2(NDRV) : 1;

  logic [NDRV-1:0]              drv_driving;
  logic [NDRV-1:0][NLANES-1:0]  drv_lanes;
  logic [NDRV-1:0][WIDTH-1:0]   drv_data;
  logic                         idle_hold;
  logic                         clr_status;

  logic [WIDTH-1:0]             ebus_data;
  logic                         ebus_active;
  logic [NLANES-1:0][OW-1:0]    lane_owner;
  logic                         contend;
  logic [NLANES-1:0]            contend_lanes;
  logic                         handoff_err;
  logic [CNTW-1:0]              contend_cnt;

  modport master (
    output drv_driving, drv_lanes, drv_data, idle_hold, clr_status,
    input  ebus_data, ebus_active, lane_owner, contend, contend_lanes, handoff_err, contend_cnt
  );

  modport slave (
    input  drv_driving, drv_lanes, drv_data, idle_hold, clr_status,
    output ebus_data, ebus_active, lane_owner, contend, contend_lanes, handoff_err, contend_cnt
  );
endinterface

// File: rtl/ebus_lane_arbiter.sv
// Per-lane priority merger for the EBUS: lowest-index claimant wins each lane, output registered,
// with sticky contention / handoff diagnostics. Lane L occupies vector bits [L*LANEW +: LANEW].
module ebus_lane_arbiter #(
  parameter int NDRV  = 32,
  parameter int WIDTH = 36,
  parameter int LANEW = 6,
  parameter int CNTW  = 16
) (
  input logic                 clk,
  input logic                 reset_l,
  ebus_lane_arbiter_if.slave  bus
);
  localparam int NLANES = WIDTH / LANEW;
  localparam int OW     = (NDRV > 1) ? $clog2(NDRV) : 1;
  localparam int VW     = NLANES * (OW + 1);

  generate
    if (WIDTH % LANEW != 0) begin : g_bad_width
      $error("ebus_lane_arbiter: WIDTH must be a multiple of LANEW");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, OWNED, HANDOFF} state_t;

  logic [NLANES-1:0]          lane_hit;
  logic [NLANES-1:0]          lane_con;
  logic [NLANES-1:0][OW-1:0]  owner;
  logic [WIDTH-1:0]           data_nxt;

  generate
    for (genvar l = 0; l < NLANES; l++) begin : g_lane
      logic [NDRV-1:0]  clm;
      logic [OW-1:0]    win;
      logic [LANEW-1:0] sel;

      always_comb begin
        clm = '0;
        for (int i = 0; i < NDRV; i++) clm[i] = bus.drv_driving[i] & bus.drv_lanes[i][l];
      end

      // Scan from the bottom of the priority order so the lowest index overwrites last.
      always_comb begin
        win = '0;
        sel = '0;
        for (int i = NDRV - 1; i >= 0; i--) begin
          if (clm[i]) begin
            win = OW'(i);
            sel = bus.drv_data[i][l*LANEW +: LANEW];
          end
        end
      end

      assign lane_hit[l] = |clm;
      assign lane_con[l] = |(clm & (clm - NDRV'(1)));
      assign owner[l]    = win;
      assign data_nxt[l*LANEW +: LANEW] = lane_hit[l] ? sel :
                                          (bus.idle_hold ? bus.ebus_data[l*LANEW +: LANEW] : '0);
    end
  endgenerate

  // Owner vector: claimed mask plus per-lane winner (winner is 0 on unclaimed lanes).
  logic [VW-1:0] ovec, ovec_q;
  assign ovec = {lane_hit, owner};

  logic   any_claim, any_con;
  assign any_claim = |lane_hit;
  assign any_con   = |lane_con;

  state_t state, state_nxt;
  logic   herr_set, latch;

  always_comb begin
    state_nxt = state;
    herr_set  = 1'b0;
    latch     = 1'b0;
    case (state)
      IDLE: begin
        if (any_claim) begin
          state_nxt = OWNED;
          latch     = 1'b1;
        end
      end
      OWNED, HANDOFF: begin
        if (!any_claim) begin
          state_nxt = IDLE;
        end else if (ovec != ovec_q) begin
          state_nxt = HANDOFF;
          herr_set  = 1'b1;
          latch     = 1'b1;
        end else begin
          state_nxt = OWNED;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_l) begin
      state             <= IDLE;
      ovec_q            <= '0;
      bus.ebus_data     <= '0;
      bus.ebus_active   <= 1'b0;
      bus.lane_owner    <= '0;
      bus.contend       <= 1'b0;
      bus.contend_lanes <= '0;
      bus.handoff_err   <= 1'b0;
      bus.contend_cnt   <= '0;
    end else begin
      state           <= state_nxt;
      if (latch) ovec_q <= ovec;
      bus.ebus_data   <= data_nxt;
      bus.ebus_active <= any_claim;
      bus.lane_owner  <= owner;
      // A clear in the same cycle as a new event leaves just that event recorded.
      if (bus.clr_status) begin
        bus.contend       <= any_con;
        bus.contend_lanes <= lane_con;
        bus.handoff_err   <= herr_set;
        bus.contend_cnt   <= CNTW'(any_con);
      end else begin
        bus.contend       <= bus.contend | any_con;
        bus.contend_lanes <= bus.contend_lanes | lane_con;
        bus.handoff_err   <= bus.handoff_err | herr_set;
        if (any_con && (bus.contend_cnt != {CNTW{1'b1}}))
          bus.contend_cnt <= bus.contend_cnt + CNTW'(1);
      end
    end
  end
endmodule

// File: tb/tb_ebus_lane_arbiter.sv
// Directed + random bench for ebus_lane_arbiter against a cycle-level model built from the lane rules.
// A second instance with a 2-bit counter shares the inputs to cover saturation.
module tb_ebus_lane_arbiter;
  localparam int NDRV = 32, WIDTH = 36, LANEW = 6, NL = 6, OW = 5;

  logic clk, reset_l;
  int   total = 0, bad = 0;

  ebus_lane_arbiter_if #(.NDRV(NDRV), .WIDTH(WIDTH), .LANEW(LANEW), .CNTW(16)) bus ();
  ebus_lane_arbiter_if #(.NDRV(NDRV), .WIDTH(WIDTH), .LANEW(LANEW), .CNTW(2))  bus2 ();

  assign bus2.drv_driving = bus.drv_driving;
  assign bus2.drv_lanes   = bus.drv_lanes;
  assign bus2.drv_data    = bus.drv_data;
  assign bus2.idle_hold   = bus.idle_hold;
  assign bus2.clr_status  = bus.clr_status;

  ebus_lane_arbiter #(.NDRV(NDRV), .WIDTH(WIDTH), .LANEW(LANEW), .CNTW(16)) dut (
    .clk(clk), .reset_l(reset_l), .bus(bus));
  ebus_lane_arbiter #(.NDRV(NDRV), .WIDTH(WIDTH), .LANEW(LANEW), .CNTW(2)) dut2 (
    .clk(clk), .reset_l(reset_l), .bus(bus2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference state
  logic [WIDTH-1:0] ed;
  logic             ea, ec, eh, pany;
  logic [NL-1:0]    ecl;
  int               ecnt;
  int               own[NL], pown[NL];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Next registered outputs from the inputs present before the coming edge.
  task automatic model();
    int ncl[NL];
    logic anyc, ho, anycl;
    logic [NL-1:0] cmask;
    if (!reset_l) begin
      ed = '0; ea = 0; ec = 0; eh = 0; ecl = '0; ecnt = 0; pany = 0;
      for (int l = 0; l < NL; l++) begin own[l] = -1; pown[l] = -1; end
      return;
    end
    anyc = 0; ho = 0; cmask = '0;
    for (int l = 0; l < NL; l++) begin
      own[l] = -1; ncl[l] = 0;
      for (int i = 0; i < NDRV; i++)
        if (bus.drv_driving[i] && bus.drv_lanes[i][l]) begin
          if (own[l] < 0) own[l] = i;
          ncl[l]++;
        end
      if (own[l] >= 0) begin
        anyc = 1;
        ed[l*LANEW +: LANEW] = bus.drv_data[own[l]][l*LANEW +: LANEW];
      end else if (!bus.idle_hold) begin
        ed[l*LANEW +: LANEW] = '0;
      end
      cmask[l] = (ncl[l] > 1);
      if (own[l] != pown[l]) ho = 1;
    end
    ho    = ho && pany && anyc;
    anycl = |cmask;
    ea    = anyc;
    if (bus.clr_status) begin
      ec = anycl; ecl = cmask; eh = ho; ecnt = anycl ? 1 : 0;
    end else begin
      ec = ec | anycl; ecl = ecl | cmask; eh = eh | ho; ecnt = ecnt + (anycl ? 1 : 0);
    end
    pany = anyc;
    for (int l = 0; l < NL; l++) pown[l] = own[l];
  endtask

  task automatic check_all(input string tag);
    logic [NL-1:0][OW-1:0] eo;
    for (int l = 0; l < NL; l++) eo[l] = (own[l] < 0) ? '0 : OW'(own[l]);
    chk({tag, ".data"},   64'(bus.ebus_data), 64'(ed));
    chk({tag, ".active"}, 64'(bus.ebus_active), 64'(ea));
    chk({tag, ".owner"},  64'(bus.lane_owner), 64'(eo));
    chk({tag, ".contend"}, 64'(bus.contend), 64'(ec));
    chk({tag, ".clanes"}, 64'(bus.contend_lanes), 64'(ecl));
    chk({tag, ".herr"},   64'(bus.handoff_err), 64'(eh));
    chk({tag, ".cnt"},    64'(bus.contend_cnt), 64'((ecnt > 65535) ? 65535 : ecnt));
    chk({tag, ".cnt2"},   64'(bus2.contend_cnt), 64'((ecnt > 3) ? 3 : ecnt));
    chk({tag, ".data2"},  64'(bus2.ebus_data), 64'(ed));
  endtask

  task automatic step(input string tag);
    model();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle_all();
    bus.drv_driving = '0;
    bus.drv_lanes   = '0;
    bus.drv_data    = '0;
  endtask

  task automatic drive(input int i, input logic [NL-1:0] m, input logic [WIDTH-1:0] d);
    bus.drv_driving[i] = 1'b1;
    bus.drv_lanes[i]   = m;
    bus.drv_data[i]    = d;
  endtask

  initial begin
    logic [63:0] r;
    logic [WIDTH-1:0] w;
    reset_l = 1'b0;
    bus.idle_hold = 1'b0;
    bus.clr_status = 1'b0;
    idle_all();

    // Reset with a driver active
    drive(5, 6'h3f, 36'o123456701234);
    step("rst0");
    step("rst1");
    reset_l = 1'b1;
    step("full5");
    chk("full5.literal", 64'(bus.ebus_data), 64'(36'o123456701234));
    step("full5b");

    // Split word, one lane per driver 8..13 (idle first so it is not a handoff)
    idle_all();
    step("gap1");
    for (int l = 0; l < NL; l++) begin
      r = {$urandom, $urandom};
      drive(8 + l, NL'(1 << l), r[WIDTH-1:0]);
    end
    step("split");
    step("split2");

    // Contention on lane 0: drivers 2 and 7
    idle_all();
    step("gap2");
    drive(2, 6'b000001, 36'o111111111111);
    drive(7, 6'b000001, 36'o777777777777);
    step("con1");
    step("con2");
    step("con3");
    bus.clr_status = 1'b1;
    step("conclr");
    bus.clr_status = 1'b0;
    for (int k = 0; k < 5; k++) step("consat");

    // Handoff 3 -> 4 back to back, then with an idle gap after clearing
    idle_all();
    bus.clr_status = 1'b1;
    step("gap3");
    bus.clr_status = 1'b0;
    drive(3, 6'h3f, 36'o333333333333);
    step("ho3");
    idle_all();
    drive(4, 6'h3f, 36'o444444444444);
    step("ho4");
    idle_all();
    bus.clr_status = 1'b1;
    step("hoclr");
    bus.clr_status = 1'b0;
    drive(3, 6'h3f, 36'o333333333333);
    step("nh3");
    idle_all();
    step("nhgap");
    drive(4, 6'h3f, 36'o444444444444);
    step("nh4");

    // Idle hold
    idle_all();
    step("gap4");
    drive(0, 6'h3f, 36'o777);
    step("d777");
    idle_all();
    bus.idle_hold = 1'b1;
    step("hold1");
    step("hold2");
    chk("hold.literal", 64'(bus.ebus_data), 64'(36'o777));
    bus.idle_hold = 1'b0;
    step("zero");

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      idle_all();
      if ($urandom_range(0, 3) != 0) begin
        for (int i = 0; i < NDRV; i++) begin
          if ($urandom_range(0, 11) == 0) begin
            r = {$urandom, $urandom};
            w = r[WIDTH-1:0];
            drive(i, ($urandom_range(0, 2) == 0) ? 6'h3f : NL'($urandom), w);
          end
        end
      end
      bus.idle_hold  = 1'($urandom_range(0, 1));
      bus.clr_status = ($urandom_range(0, 9) == 0);
      reset_l        = ($urandom_range(0, 59) != 0);
      step("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
